sm_imem_loader: RTL and testbench
=================================

// Module: sm_imem_loader
// PURPOSE
//  Word-addressed instruction memory with a byte-stream program loader. Sits directly
//  upstream of the CPU: it serves imAddr -> imData combinationally and drives the CPU reset.
//  Assembles incoming bytes into 32-bit little-endian words and writes them from word 0 up.
//  Holds the CPU in reset while a load is in progress, then releases it to run from pc=0.
// PARAMETERS
//  ADDR_WIDTH   6   log2 of memory depth in 32-bit words (default 64 words)
// PORTS
//  clk          in   1             clock
//  rst_n        in   1             reset, asynchronous, active-low
//  load_start   in   1             start a load; sampled only in IDLE
//  load_len     in   ADDR_WIDTH+1  number of words to load; sampled with load_start
//  byte_valid   in   1             byte_data is valid
//  byte_data    in   8             program byte, LSB of each word first
//  byte_ready   out  1             loader accepts a byte this cycle
//  busy         out  1             state != IDLE
//  done         out  1             one-cycle pulse when the load completes
//  cpu_rst_n    out  1             reset to the CPU, active-low
//  imAddr       in   32            CPU instruction word address (pc)
//  imData       out  32            instruction word at imAddr[ADDR_WIDTH-1:0]
// BEHAVIOUR
//  - Reset values: state=IDLE, byte_ready=0, busy=0, done=0, cpu_rst_n=0, word/byte counters=0,
//    assembly register=0. Memory contents are not reset.
//  - cpu_rst_n is a register that loads (next_state==IDLE) each edge. It goes to 1 on the first
//    edge after rst_n deasserts while in IDLE, and is 0 in LOAD and DONE.
//  - Read port: imData = mem[imAddr[ADDR_WIDTH-1:0]], combinational, zero latency.
//    Upper imAddr bits are ignored, so addresses wrap.
//  - FSM IDLE: load_start=1 -> latch load_len. If load_len==0, go to DONE; otherwise go to LOAD.
//    load_len > 2**ADDR_WIDTH is clamped to 2**ADDR_WIDTH.
//  - FSM LOAD: byte_ready=1. A byte is accepted on an edge with byte_valid & byte_ready.
//    Byte k (k=0..3) goes to word bits [8k+7:8k].
//    On the 4th accepted byte, mem[word_cnt] <= {byte_data, assembled[23:0]} at that same edge,
//    word_cnt increments, and byte_cnt returns to 0.
//    When the word written is word load_len-1, the next state is DONE.
//  - FSM DONE: done=1 for exactly one cycle, then IDLE. The CPU leaves reset one edge later.
//  - load_start is ignored in LOAD and DONE. byte_valid is ignored outside LOAD (byte_ready=0).
//  - Gaps in byte_valid stall the loader indefinitely. There is no timeout.
//  - Read during write of the same address in the same cycle returns the old contents.
//  - Async reset mid-load: return to IDLE immediately and discard the partial word.
//    Words already written are kept. cpu_rst_n=0 while rst_n=0.
//  - Memory is written only by the loader; the CPU has no write path.
// TESTING
//  1 Reset: rst_n=0 -> all outputs 0. Release -> cpu_rst_n=1 on the next edge, busy=0.
//  2 Load 2 words: load_len=2, bytes 78 56 34 12 EF BE AD DE.
//    Required: mem[0]=0x12345678, mem[1]=0xDEADBEEF; done pulses 1 cycle after the 8th byte;
//    cpu_rst_n=0 from the cycle after load_start until 1 cycle after done;
//    imAddr=1 -> imData=0xDEADBEEF.
//  3 Stalled stream: same bytes as test 2 with byte_valid low for 3 cycles between each byte.
//    Required: identical memory contents, no duplicate writes, and done only after the last byte.
//  4 Zero length: load_len=0 -> IDLE->DONE->IDLE, done pulse, no memory write, byte_ready stays 0.
//  5 Abort: assert rst_n=0 after 5 bytes of a 2-word load.
//    Required: mem[0] holds word 0 and mem[1] is unchanged; a new load after release works.
//  6 Wrap and clamp: ADDR_WIDTH=2, load_len=7 -> exactly 4 words written, then done.
//    Also imAddr=5 -> imData=mem[1], and load_start asserted during LOAD is ignored.

Source files
------------

// File: rtl/sm_imem_loader.sv
// Word-addressed instruction memory fed by a byte-stream loader; gates CPU reset while loading.
// Read: zero latency. Load: word written on the edge taking its 4th byte; done one cycle after last byte.
// Backpressure: byte_ready only in LOAD; gaps in byte_valid stall the loader without limit.
module sm_imem_loader #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  cpu_rst_n,
    input  logic [31:0]           imAddr,
    output logic [31:0]           imData
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                state;
    state_t                nextState;
    logic [ADDR_WIDTH:0]   lenReg;
    logic [ADDR_WIDTH:0]   wordCnt;
    logic [1:0]            byteCnt;
    logic [23:0]           assembled;
    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH:0]   lenClamped;
    logic                  byteTake;
    logic                  wordDone;
    logic                  lastWord;
    logic                  unusedImAddr;

    assign lenClamped = (load_len > MAX_LEN) ? MAX_LEN : load_len;
    assign byteTake   = (state == LOAD) && byte_valid;
    assign wordDone   = byteTake && (byteCnt == 2'd3);
    assign lastWord   = (wordCnt == lenReg - (ADDR_WIDTH + 1)'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (load_start) begin
                    nextState = (lenClamped == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (wordDone && lastWord) begin
                    nextState = DONE;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = (state == LOAD);
        busy       = (state != IDLE);
        done       = (state == DONE);
    end

    // CPU reset follows the next state so it releases on the same edge the loader returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rst_n <= 1'b0;
            lenReg    <= '0;
            wordCnt   <= '0;
            byteCnt   <= 2'd0;
            assembled <= 24'd0;
        end else begin
            cpu_rst_n <= (nextState == IDLE);
            if (state == IDLE && load_start) begin
                lenReg    <= lenClamped;
                wordCnt   <= '0;
                byteCnt   <= 2'd0;
                assembled <= 24'd0;
            end else if (byteTake) begin
                byteCnt <= byteCnt + 2'd1;
                case (byteCnt)
                    2'd0:    assembled[7:0]   <= byte_data;
                    2'd1:    assembled[15:8]  <= byte_data;
                    2'd2:    assembled[23:16] <= byte_data;
                    default: begin
                        assembled <= 24'd0;
                        wordCnt   <= wordCnt + (ADDR_WIDTH + 1)'(1);
                    end
                endcase
            end
        end
    end

    // Memory has no reset so words survive an aborted load.
    always_ff @(posedge clk) begin
        if (wordDone) begin
            mem[wordCnt[ADDR_WIDTH-1:0]] <= {byte_data, assembled};
        end
    end

    assign imData       = mem[imAddr[ADDR_WIDTH-1:0]];
    assign unusedImAddr = ^imAddr[31:ADDR_WIDTH];

endmodule

// File: tb/tb_sm_imem_loader.sv
// Randomized bench for sm_imem_loader: a 64-word and a 4-word instance checked against a word-array model.
module tb_sm_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        lsA, bvA, brA, bzA, dnA, crA;
    logic [6:0]  llA;
    logic [7:0]  bdA;
    logic [31:0] iaA, idA;
    logic        lsB, bvB, brB, bzB, dnB, crB;
    logic [2:0]  llB;
    logic [7:0]  bdB;
    logic [31:0] iaB, idB;

    int          vecCnt = 0;
    int          errCnt = 0;
    logic [31:0] mdl [2][64];
    bit          known [2][64];
    logic [7:0]  fixedQ [$];

    always #5 clk = ~clk;

    sm_imem_loader #(.ADDR_WIDTH(6)) dutA (
        .clk(clk), .rst_n(rst_n), .load_start(lsA), .load_len(llA),
        .byte_valid(bvA), .byte_data(bdA), .byte_ready(brA), .busy(bzA),
        .done(dnA), .cpu_rst_n(crA), .imAddr(iaA), .imData(idA)
    );

    sm_imem_loader #(.ADDR_WIDTH(2)) dutB (
        .clk(clk), .rst_n(rst_n), .load_start(lsB), .load_len(llB),
        .byte_valid(bvB), .byte_data(bdB), .byte_ready(brB), .busy(bzB),
        .done(dnB), .cpu_rst_n(crB), .imAddr(iaB), .imData(idB)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int cap(input int d);
        return (d == 0) ? 64 : 4;
    endfunction

    // {byte_ready, busy, done, cpu_rst_n}
    function automatic logic [3:0] flags(input int d);
        return (d == 0) ? {brA, bzA, dnA, crA} : {brB, bzB, dnB, crB};
    endfunction

    function automatic logic [31:0] rd(input int d);
        return (d == 0) ? idA : idB;
    endfunction

    task automatic drive(input int d, input logic ls, input logic [6:0] ll,
                         input logic bv, input logic [7:0] bd);
        if (d == 0) begin
            lsA = ls; llA = ll; bvA = bv; bdA = bd;
        end else begin
            lsB = ls; llB = ll[2:0]; bvB = bv; bdB = bd;
        end
    endtask

    task automatic setAddr(input int d, input logic [31:0] a);
        if (d == 0) iaA = a;
        else        iaB = a;
    endtask

    function automatic logic [6:0] noiseLen(input int d);
        return (d == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 7));
    endfunction

    // One load transaction; gap<0 means random stalls; abortAt = byte count after which rst_n pulses.
    task automatic doLoad(input int d, input int len, input int gap, input int abortAt);
        int          eff;
        int          nb;
        int          g;
        int          wi;
        logic [7:0]  bv;
        logic [31:0] w;
        eff = (len > cap(d)) ? cap(d) : len;
        nb  = eff * 4;
        w   = 32'd0;
        drive(d, 1'b1, 7'(len), 1'b0, 8'h00);
        @(posedge clk); #1;
        chk("start_flags", 32'(flags(d)), (eff == 0) ? 32'b0110 : 32'b1100);
        if (eff == 0) begin
            drive(d, 1'b0, 7'd0, 1'b1, 8'hA5);
            @(posedge clk); #1;
            chk("zero_end_flags", 32'(flags(d)), 32'b0001);
            drive(d, 1'b0, 7'd0, 1'b0, 8'h00);
            return;
        end
        for (int b = 0; b < nb; b++) begin
            g = (gap < 0) ? $urandom_range(0, 2) : gap;
            for (int s = 0; s < g; s++) begin
                drive(d, 1'($urandom), noiseLen(d), 1'b0, 8'($urandom));
                @(posedge clk); #1;
                chk("stall_flags", 32'(flags(d)), 32'b1100);
            end
            bv = (fixedQ.size() > 0) ? fixedQ.pop_front() : 8'($urandom);
            drive(d, 1'($urandom), noiseLen(d), 1'b1, bv);
            wi = b / 4;
            w[8*(b%4) +: 8] = bv;
            if (b % 4 == 3) begin
                setAddr(d, ($urandom & ~32'(cap(d) - 1)) | 32'(wi));
                #1;
                if (known[d][wi]) chk("rdw_old", rd(d), mdl[d][wi]);
            end
            @(posedge clk); #1;
            if (b % 4 == 3) begin
                mdl[d][wi]   = w;
                known[d][wi] = 1'b1;
                chk("word_write", rd(d), w);
            end
            chk("byte_flags", 32'(flags(d)), (b == nb - 1) ? 32'b0110 : 32'b1100);
            if (b + 1 == abortAt) begin
                rst_n = 1'b0;
                #1;
                chk("abort_flags", 32'(flags(d)), 32'b0000);
                drive(d, 1'b0, 7'd0, 1'b0, 8'h00);
                @(posedge clk); #1;
                chk("abort_hold", 32'(flags(d)), 32'b0000);
                rst_n = 1'b1;
                @(posedge clk); #1;
                chk("abort_release", 32'(flags(d)), 32'b0001);
                fixedQ.delete();
                return;
            end
        end
        drive(d, 1'b0, 7'd0, 1'b0, 8'h00);
        @(posedge clk); #1;
        chk("end_flags", 32'(flags(d)), 32'b0001);
    endtask

    task automatic memCheck(input int d);
        for (int i = 0; i < cap(d); i++) begin
            if (known[d][i]) begin
                setAddr(d, ($urandom & ~32'(cap(d) - 1)) | 32'(i));
                #1;
                chk("mem_read", rd(d), mdl[d][i]);
            end
        end
    endtask

    task automatic idleNoise(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            drive(d, 1'b0, noiseLen(d), 1'b1, 8'($urandom));
            @(posedge clk); #1;
            chk("idle_flags", 32'(flags(d)), 32'b0001);
        end
        drive(d, 1'b0, 7'd0, 1'b0, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 7'd0, 1'b0, 8'h00);
        drive(1, 1'b0, 7'd0, 1'b0, 8'h00);
        setAddr(0, 32'd0);
        setAddr(1, 32'd0);
        #12;
        chk("reset_flags_a", 32'(flags(0)), 32'b0000);
        chk("reset_flags_b", 32'(flags(1)), 32'b0000);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("release_flags_a", 32'(flags(0)), 32'b0001);
        chk("release_flags_b", 32'(flags(1)), 32'b0001);

        fixedQ = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        doLoad(0, 2, 0, -1);
        setAddr(0, 32'd1); #1;
        chk("two_word_w1", rd(0), 32'hDEADBEEF);
        setAddr(0, 32'd0); #1;
        chk("two_word_w0", rd(0), 32'h12345678);

        idleNoise(0, 3);
        setAddr(0, 32'd0); #1;
        chk("idle_bytes_ignored", rd(0), 32'h12345678);

        fixedQ = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        doLoad(0, 2, 3, -1);
        setAddr(0, 32'd64 + 32'd1); #1;
        chk("stall_w1_wrap", rd(0), 32'hDEADBEEF);

        doLoad(0, 0, 0, -1);
        idleNoise(0, 2);

        doLoad(0, 2, 1, 5);
        memCheck(0);
        setAddr(0, 32'd1); #1;
        chk("abort_w1_kept", rd(0), 32'hDEADBEEF);
        doLoad(0, 3, -1, -1);
        memCheck(0);

        doLoad(1, 7, -1, -1);
        setAddr(1, 32'd5); #1;
        chk("clamp_wrap_addr5", rd(1), mdl[1][1]);
        memCheck(1);

        for (int t = 0; t < 14; t++) begin
            int d;
            int len;
            int ab;
            d   = $urandom_range(0, 1);
            len = (d == 0) ? $urandom_range(0, 70) : $urandom_range(0, 7);
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 16) : -1;
            doLoad(d, len, -1, ab);
            idleNoise(d, $urandom_range(0, 2));
        end
        memCheck(0);
        memCheck(1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
